// File: rtl/pcm_dc_block_fifo_pkg.sv
// Shared types, limits and saturation helpers for the PCM DC-block / FIFO stage.
// Optional build macro used elsewhere in this slice: PCM_PEAK_METER_EN.
package pcm_pkg;

    typedef logic signed [15:0] pcm_sample_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } pcm_state_e;

    localparam pcm_sample_t PCM_MAX = 16'sh7FFF;
    localparam pcm_sample_t PCM_MIN = 16'sh8000;

    // Clamp a wide signed value into the 16-bit PCM range.
    function automatic pcm_sample_t sat16(input logic signed [31:0] v);
        pcm_sample_t r;
        if (v > 32'sd32767) begin
            r = PCM_MAX;
        end else if (v < -32'sd32768) begin
            r = PCM_MIN;
        end else begin
            r = 16'(v);
        end
        return r;
    endfunction

    // Magnitude of a sample; -32768 has no positive twin so it maps to 32767.
    function automatic pcm_sample_t abs16(input pcm_sample_t v);
        pcm_sample_t r;
        if (v == PCM_MIN) begin
            r = PCM_MAX;
        end else if (v < 16'sd0) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/pcm_dc_block_fifo_if.sv
// AXI4-Stream style sample channel carried out of pcm_dc_block_fifo.
interface pcm_axis_if;
    import pcm_pkg::*;

    pcm_sample_t tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pcm_dc_block_fifo_fifo.sv
// Synchronous FIFO with exact occupancy, flush, and empty-gated read data.
// A write to a full FIFO is accepted only when a read happens in the same cycle.
module pcm_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_wr_s, do_rd_s;

    // Flags, handshake qualification and next pointer/level values.
    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        do_rd_s = rd_en && !empty && !flush;
        do_wr_s = wr_en && (!full || do_rd_s) && !flush;
        if (empty) begin
            rd_data = '0;
        end else begin
            rd_data = mem_q[rd_ptr_q];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_rd_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage; contents are never observed while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign level = level_q;
endmodule

// File: rtl/pcm_dc_block_fifo.sv
// PCM post-processing: settle gate, one-pole DC blocker, power-of-two gain with
// saturation, and an output FIFO presented as a stream master. The source has no
// ready, so a full FIFO drops samples and sets a sticky overflow flag.
// Optional build macro: PCM_PEAK_METER_EN adds peak_level / peak_clear.
module pcm_dc_block_fifo
    import pcm_pkg::*;
#(
    parameter int ALPHA_SHIFT  = 8,
    parameter int SETTLE_COUNT = 64,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          dc_bypass,
    input  logic [2:0]                    gain_shift,
    input  pcm_sample_t                   in_data,
    input  logic                          in_valid,
    pcm_axis_if.master                    m,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clear
`ifdef PCM_PEAK_METER_EN
    ,
    output logic [15:0]                   peak_level,
    input  logic                          peak_clear
`endif
);
    localparam int ACC_W = 16 + ALPHA_SHIFT + 2;
    localparam int Y_W   = ACC_W - ALPHA_SHIFT;
    localparam int CNT_W = (SETTLE_COUNT > 0) ? $clog2(SETTLE_COUNT + 1) : 1;

    pcm_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    pcm_sample_t              xprev_q, xprev_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     s2_valid_q, s2_valid_d;
    pcm_sample_t              s2_data_q, s2_data_d;
    logic                     overflow_q, overflow_d;

    logic                     clear_s, filt_en_s;
    logic signed [ACC_W-1:0]  x_ext_s, xp_ext_s, diff_s, acc_n_s;
    logic signed [Y_W-1:0]    y_s, gain_in_s;
    logic signed [31:0]       gain_ext_s, gain_wide_s;
    logic                     wr_en_s, drop_s, wr_done_s;
    logic [15:0]              fifo_rd_s;
    logic                     fifo_full_s, fifo_empty_s;

    // FSM next state, filter update and gain stage; the stage-1 sample is
    // acc_q (filtered, scaled) and xprev_q (raw), both loaded on the same edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        xprev_d    = xprev_q;
        s1_valid_d = 1'b0;
        s2_valid_d = 1'b0;
        s2_data_d  = s2_data_q;
        filt_en_s  = 1'b0;
        clear_s    = (state_q == ST_IDLE) || !enable;

        x_ext_s  = {{(ACC_W-16){in_data[15]}}, in_data};
        xp_ext_s = {{(ACC_W-16){xprev_q[15]}}, xprev_q};
        diff_s   = x_ext_s - xp_ext_s;
        acc_n_s  = acc_q + (diff_s <<< ALPHA_SHIFT) - (acc_q >>> ALPHA_SHIFT);

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (SETTLE_COUNT == 0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_W'(SETTLE_COUNT);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    filt_en_s = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    filt_en_s  = 1'b1;
                    s1_valid_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (filt_en_s) begin
            acc_d   = acc_n_s;
            xprev_d = in_data;
        end else begin
            acc_d   = acc_q;
            xprev_d = xprev_q;
        end

        y_s = Y_W'(acc_q >>> ALPHA_SHIFT);
        if (dc_bypass) begin
            gain_in_s = Y_W'(xprev_q);
        end else begin
            gain_in_s = y_s;
        end
        gain_ext_s  = 32'(gain_in_s);
        gain_wide_s = gain_ext_s <<< gain_shift;

        if (s1_valid_q) begin
            s2_valid_d = 1'b1;
            s2_data_d  = sat16(gain_wide_s);
        end else begin
            s2_valid_d = 1'b0;
            s2_data_d  = s2_data_q;
        end

        if (clear_s) begin
            acc_d      = '0;
            xprev_d    = '0;
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_d;
        end
    end

    // FIFO write qualification and sticky overflow (a new drop beats a clear).
    always_comb begin
        wr_en_s   = s2_valid_q && !clear_s;
        drop_s    = wr_en_s && fifo_full_s && !m.tready;
        wr_done_s = wr_en_s && !drop_s;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Pipeline, filter and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            xprev_q    <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            xprev_q    <= xprev_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            overflow_q <= overflow_d;
        end
    end

    pcm_sync_fifo #(
        .DATA_W (16),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (clear_s),
        .wr_en   (wr_en_s),
        .wr_data (s2_data_q),
        .rd_en   (m.tready),
        .rd_data (fifo_rd_s),
        .level   (fifo_level),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign m.tvalid = !fifo_empty_s;
    assign m.tdata  = fifo_rd_s;
    assign overflow = overflow_q;

`ifdef PCM_PEAK_METER_EN
    pcm_sample_t peak_q, peak_d, peak_base_s, wr_abs_s;

    // Peak magnitude over accepted writes; a clear restarts from this cycle's write.
    always_comb begin
        wr_abs_s = abs16(s2_data_q);
        if (peak_clear) begin
            peak_base_s = 16'sd0;
        end else begin
            peak_base_s = peak_q;
        end
        if (wr_done_s && (wr_abs_s > peak_base_s)) begin
            peak_d = wr_abs_s;
        end else begin
            peak_d = peak_base_s;
        end
    end

    // Peak register.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`endif
endmodule

// File: tb/tb_pcm_dc_block_fifo.sv
// Directed bench for pcm_dc_block_fifo (SETTLE_COUNT=4, FIFO_DEPTH=16, ALPHA_SHIFT=8).
module tb_pcm_dc_block_fifo;
    import pcm_pkg::*;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        dc_bypass;
    logic [2:0]  gain_shift;
    pcm_sample_t in_data;
    logic        in_valid;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        ovf_clear;
`ifdef PCM_PEAK_METER_EN
    logic [15:0] peak_level;
    logic        peak_clear;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pcm_axis_if axis ();

    pcm_dc_block_fifo #(
        .ALPHA_SHIFT  (8),
        .SETTLE_COUNT (4),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dc_bypass  (dc_bypass),
        .gain_shift (gain_shift),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .m          (axis),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear)
`ifdef PCM_PEAK_METER_EN
        ,
        .peak_level (peak_level),
        .peak_clear (peak_clear)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input pcm_sample_t d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic restart();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    task automatic settle(input pcm_sample_t d);
        for (int i = 0; i < 4; i++) strobe(d);
    endtask

    task automatic drain_check(input string tag, input logic signed [31:0] exp);
        chk({tag, "_valid"}, axis.tvalid, 1);
        chk(tag, axis.tdata, exp);
        axis.tready = 1'b1;
        tick();
        axis.tready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        dc_bypass   = 1'b0;
        gain_shift  = 3'd0;
        in_data     = 16'sd0;
        in_valid    = 1'b0;
        ovf_clear   = 1'b0;
        axis.tready = 1'b0;
`ifdef PCM_PEAK_METER_EN
        peak_clear  = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_tdata", axis.tdata, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
`ifdef PCM_PEAK_METER_EN
        chk("rst_peak", peak_level, 0);
`endif
        reset = 1'b0;
        tick();

        // 1: four settle samples discarded, two produced (filter output 984, 980)
        enable = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) strobe(16'sd1000);
        repeat (3) tick();
        chk("t1_level", fifo_level, 2);
        drain_check("t1_out0", 984);
        drain_check("t1_out1", 980);
        chk("t1_empty", axis.tvalid, 0);

        // 2: DC decays away; bypass passes raw input
        restart();
        axis.tready = 1'b1;
        for (int i = 0; i < 3004; i++) strobe(16'sd5000);
        repeat (3) tick();
        axis.tready = 1'b0;
        chk("t2_drained", fifo_level, 0);
        strobe(16'sd5000);
        repeat (3) tick();
        chk("t2_level", fifo_level, 1);
        chk("t2_decay_small", (axis.tdata <= 16'sd2) && (axis.tdata >= -16'sd2), 1);
        axis.tready = 1'b1;
        tick();
        axis.tready = 1'b0;
        dc_bypass = 1'b1;
        strobe(16'sd5000);
        repeat (3) tick();
        drain_check("t2_bypass", 5000);
        dc_bypass = 1'b0;

        // 3: gain saturation on steps (y = 20000 then -20079, x8)
        restart();
        gain_shift = 3'd3;
        settle(16'sd0);
        strobe(16'sd0);
        strobe(16'sd20000);
        strobe(-16'sd20000);
        repeat (3) tick();
        chk("t3_level", fifo_level, 3);
        drain_check("t3_zero", 0);
        drain_check("t3_sat_pos", 32767);
        drain_check("t3_sat_neg", -32768);
        gain_shift = 3'd0;

        // 4: overflow with two drops, order preserved
        restart();
        dc_bypass = 1'b1;
        settle(16'sd0);
        for (int i = 0; i < 18; i++) strobe(pcm_sample_t'(i * 100 + 7));
        repeat (3) tick();
        chk("t4_level_full", fifo_level, 16);
        chk("t4_overflow", overflow, 1);
        for (int i = 0; i < 16; i++) drain_check("t4_order", i * 100 + 7);
        chk("t4_empty", axis.tvalid, 0);

        // 5: write into full FIFO with simultaneous read; overflow clear rules
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("t5_ovf_cleared", overflow, 0);
        for (int i = 0; i < 16; i++) strobe(pcm_sample_t'(1000 + i));
        repeat (3) tick();
        chk("t5_full", fifo_level, 16);
        strobe(16'sd5555);
        tick();
        axis.tready = 1'b1;
        tick();
        axis.tready = 1'b0;
        chk("t5_level_same", fifo_level, 16);
        chk("t5_no_ovf", overflow, 0);
        chk("t5_head", axis.tdata, 1001);
        strobe(16'sd6666);
        tick();
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("t5_set_beats_clear", overflow, 1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("t5_clear", overflow, 0);
        for (int i = 1; i < 16; i++) drain_check("t5_order", 1000 + i);
        drain_check("t5_last", 5555);

        // 6: enable drop flushes the queue on the next edge
        for (int i = 1; i <= 5; i++) strobe(pcm_sample_t'(i));
        repeat (3) tick();
        chk("t6_level5", fifo_level, 5);
        enable = 1'b0;
        tick();
        chk("t6_tvalid", axis.tvalid, 0);
        chk("t6_level0", fifo_level, 0);

`ifdef PCM_PEAK_METER_EN
        restart();
        peak_clear = 1'b1;
        tick();
        peak_clear = 1'b0;
        chk("pk_cleared", peak_level, 0);
        settle(16'sd0);
        strobe(-16'sd32768);
        strobe(16'sd100);
        repeat (3) tick();
        chk("pk_min_sat", peak_level, 32767);
`endif

        // Reset mid-stream loses the in-flight sample
        restart();
        settle(16'sd0);
        strobe(16'sd123);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_tvalid", axis.tvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
